// File: rtl/mixer_ctrl_pkg.sv
// rtl/mixer_ctrl_pkg.sv - shared types and constants for the mixer power/gain controller
//
// Contents:
//   state_t            controller state (OFF, SETTLE, ON)
//   OTA_DEFAULT        OTA gain applied at reset
//   BUFF_DEFAULT       buffer gain applied at reset
//   gain_is_nondefault true when a gain pair differs from the reset gains
package mixer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ON     = 2'd2
    } state_t;

    localparam logic       OTA_DEFAULT  = 1'b1;
    localparam logic [1:0] BUFF_DEFAULT = 2'b01;

    function automatic logic gain_is_nondefault(input logic ota_v, input logic [1:0] buff_v);
        return (ota_v != OTA_DEFAULT) || (buff_v != BUFF_DEFAULT);
    endfunction

endpackage

// File: rtl/mixer_ctrl_settle_cnt.sv
// rtl/mixer_ctrl_settle_cnt.sv - settle timer for the mixer controller
//
// Ports:
//   clk    in   clock
//   clear  in   synchronous clear to 0 (wins over enable)
//   enable in   count one cycle of settling
//   done   out  count has reached SETTLE_CYCLES-1 (combinational from the count)
//
// The count saturates at SETTLE_CYCLES-1 so it can never wrap, even if the
// owner keeps enable high past done.
module mixer_ctrl_settle_cnt #(
    parameter int SETTLE_CYCLES = 200,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign done = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (enable && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mixer_ctrl.sv
// rtl/mixer_ctrl.sv - mixer power-up sequencing and gain control
//
// Ports:
//   clk             in   sole clock
//   rst             in   synchronous active-high reset
//   en              in   level request to power the mixer
//   cfg_valid       in   gain write request
//   cfg_ready       out  gain write accepted this cycle (OFF or ON only)
//   cfg_ota         in   requested OTA gain
//   cfg_buff        in   requested buffer gain
//   pd              out  mixer power-down, active-high
//   ota             out  mixer OTA gain
//   buff            out  mixer buffer gain
//   mixer_ready     out  mixer powered and settled
//   busy            out  settle in progress
//   gain_nondefault out  gains differ from reset values while powered
//
// Every output is a register. A gain write while ON with en held restarts the
// settle, since the mixer output is not trustworthy after a gain change.
module mixer_ctrl
    import mixer_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 200,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_ota,
    input  logic [1:0] cfg_buff,
    output logic       pd,
    output logic       ota,
    output logic [1:0] buff,
    output logic       mixer_ready,
    output logic       busy,
    output logic       gain_nondefault
);

    state_t     state;
    logic       xfer;
    logic       ota_nxt;
    logic [1:0] buff_nxt;
    logic       cnt_clear;
    logic       cnt_done;

    // cfg_ready is registered low throughout SETTLE, so it alone gates transfers.
    assign xfer     = cfg_valid && cfg_ready;
    assign ota_nxt  = xfer ? cfg_ota  : ota;
    assign buff_nxt = xfer ? cfg_buff : buff;

    // Hold the timer at 0 whenever SETTLE is not going to continue next cycle,
    // so every entry into SETTLE starts from a zero count.
    assign cnt_clear = rst || (state != ST_SETTLE) || !en || cnt_done;

    mixer_ctrl_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle_cnt (
        .clk    (clk),
        .clear  (cnt_clear),
        .enable (state == ST_SETTLE),
        .done   (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_OFF;
            pd              <= 1'b1;
            ota             <= OTA_DEFAULT;
            buff            <= BUFF_DEFAULT;
            mixer_ready     <= 1'b0;
            busy            <= 1'b0;
            cfg_ready       <= 1'b1;
            gain_nondefault <= 1'b0;
        end else begin
            ota  <= ota_nxt;
            buff <= buff_nxt;
            case (state)
                ST_OFF: begin
                    if (en) begin
                        state           <= ST_SETTLE;
                        pd              <= 1'b0;
                        busy            <= 1'b1;
                        mixer_ready     <= 1'b0;
                        cfg_ready       <= 1'b0;
                        gain_nondefault <= gain_is_nondefault(ota_nxt, buff_nxt);
                    end else begin
                        pd              <= 1'b1;
                        busy            <= 1'b0;
                        mixer_ready     <= 1'b0;
                        cfg_ready       <= 1'b1;
                        gain_nondefault <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (!en) begin
                        state           <= ST_OFF;
                        pd              <= 1'b1;
                        busy            <= 1'b0;
                        mixer_ready     <= 1'b0;
                        cfg_ready       <= 1'b1;
                        gain_nondefault <= 1'b0;
                    end else if (cnt_done) begin
                        state           <= ST_ON;
                        busy            <= 1'b0;
                        mixer_ready     <= 1'b1;
                        cfg_ready       <= 1'b1;
                        gain_nondefault <= gain_is_nondefault(ota_nxt, buff_nxt);
                    end
                end
                ST_ON: begin
                    if (!en) begin
                        state           <= ST_OFF;
                        pd              <= 1'b1;
                        busy            <= 1'b0;
                        mixer_ready     <= 1'b0;
                        cfg_ready       <= 1'b1;
                        gain_nondefault <= 1'b0;
                    end else if (xfer) begin
                        state           <= ST_SETTLE;
                        busy            <= 1'b1;
                        mixer_ready     <= 1'b0;
                        cfg_ready       <= 1'b0;
                        gain_nondefault <= gain_is_nondefault(ota_nxt, buff_nxt);
                    end
                end
                default: begin
                    state           <= ST_OFF;
                    pd              <= 1'b1;
                    busy            <= 1'b0;
                    mixer_ready     <= 1'b0;
                    cfg_ready       <= 1'b1;
                    gain_nondefault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mixer_ctrl.sv
// tb/tb_mixer_ctrl.sv - self-checking bench for mixer_ctrl with a timestamp reference model
module tb_mixer_ctrl;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst, en, cfg_valid, cfg_ota;
    logic [1:0] cfg_buff;
    logic       cfg_ready, pd, ota, mixer_ready, busy, gain_nondefault;
    logic [1:0] buff;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: powered flag, cycle at which output becomes valid, gains.
    bit       m_pow   = 1'b0;
    int       m_rdy_t = 0;
    bit       m_ota   = 1'b1;
    bit [1:0] m_buff  = 2'b01;

    always #5 clk = ~clk;

    mixer_ctrl #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_ota         (cfg_ota),
        .cfg_buff        (cfg_buff),
        .pd              (pd),
        .ota             (ota),
        .buff            (buff),
        .mixer_ready     (mixer_ready),
        .busy            (busy),
        .gain_nondefault (gain_nondefault)
    );

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        bit settling;
        bit x;
        @(posedge clk);
        cyc++;
        settling = m_pow && ((cyc - 1) < m_rdy_t);
        if (rst) begin
            m_pow  = 1'b0;
            m_ota  = 1'b1;
            m_buff = 2'b01;
        end else begin
            x = cfg_valid && !settling;
            if (x) begin
                m_ota  = cfg_ota;
                m_buff = cfg_buff;
            end
            if (!en) begin
                m_pow = 1'b0;
            end else if (!m_pow || x) begin
                m_pow   = 1'b1;
                m_rdy_t = cyc + S;
            end
        end
        #1;
        chk("pd",              pd,              !m_pow);
        chk("ota",             ota,             m_ota);
        chk("buff",            buff,            m_buff);
        chk("mixer_ready",     mixer_ready,     m_pow && (cyc >= m_rdy_t));
        chk("busy",            busy,            m_pow && (cyc < m_rdy_t));
        chk("cfg_ready",       cfg_ready,       !(m_pow && (cyc < m_rdy_t)));
        chk("gain_nondefault", gain_nondefault, m_pow && (m_ota != 1'b1 || m_buff != 2'b01));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_ota = 1'b1; cfg_buff = 2'b01;
        step();
        step();
        rst = 1'b0;

        // Reset state literals
        chk("rst_pd", pd, 1'b1);
        chk("rst_cfg_ready", cfg_ready, 1'b1);

        // Power-up: en high at cycle 10
        while (cyc < 10) step();
        en = 1'b1;
        for (int k = 11; k <= 15; k++) begin
            step();
            chk("up_pd", pd, 1'b0);
            chk("up_busy", busy, (k <= 14));
            chk("up_ready", mixer_ready, (k == 15));
        end

        // Gain write in ON -> re-settle for S cycles
        cfg_valid = 1'b1; cfg_ota = 1'b0; cfg_buff = 2'b10;
        step();
        cfg_valid = 1'b0;
        chk("wr_ota", ota, 1'b0);
        chk("wr_buff", buff, 2'b10);
        chk("wr_gnd", gain_nondefault, 1'b1);
        for (int k = 0; k < S; k++) begin
            chk("wr_ready_low", mixer_ready, 1'b0);
            step();
        end
        chk("wr_ready_high", mixer_ready, 1'b1);

        // Abort a settle two cycles in, then full restart
        en = 1'b0; step();
        en = 1'b1; step(); step();
        en = 1'b0; step();
        chk("abort_pd", pd, 1'b1);
        en = 1'b1;
        for (int k = 0; k < S + 2; k++) step();
        chk("restart_ready", mixer_ready, 1'b1);

        // cfg_valid held through a settle
        en = 1'b0; step();
        en = 1'b1; step();
        cfg_valid = 1'b1; cfg_ota = 1'b1; cfg_buff = 2'b11;
        for (int k = 0; k < S; k++) begin
            step();
            if (k < S - 1) chk("hold_no_change", buff, 2'b10);
        end
        step();
        cfg_valid = 1'b0;
        chk("hold_accept_buff", buff, 2'b11);
        chk("hold_resettle_busy", busy, 1'b1);

        // Reset mid-settle with ota=0
        for (int k = 0; k < S; k++) step();
        cfg_valid = 1'b1; cfg_ota = 1'b0; cfg_buff = 2'b00;
        step();
        cfg_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_pd", pd, 1'b1);
        chk("midrst_ota", ota, 1'b1);
        chk("midrst_buff", buff, 2'b01);
        chk("midrst_busy", busy, 1'b0);

        // Write in OFF, then en=0 and write in ON at the same cycle
        en = 1'b0; cfg_valid = 1'b1; cfg_ota = 1'b0; cfg_buff = 2'b11;
        step();
        cfg_valid = 1'b0;
        chk("off_wr_ota", ota, 1'b0);
        chk("off_wr_pd", pd, 1'b1);
        en = 1'b1;
        for (int k = 0; k < S + 1; k++) step();
        en = 1'b0; cfg_valid = 1'b1; cfg_ota = 1'b1; cfg_buff = 2'b10;
        step();
        cfg_valid = 1'b0;
        chk("on_off_wr_buff", buff, 2'b10);
        chk("on_off_wr_pd", pd, 1'b1);
        chk("on_off_wr_gnd", gain_nondefault, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 11) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ota   = 1'($urandom);
            cfg_buff  = 2'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mixer_ctrl.md
MIXER_CTRL -- requirements
Module: mixer_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 200: cycles from pd deassert or gain change until mixer output is valid; legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default 16: settle counter width; SETTLE_CYCLES <= 2**CNT_W-1.
REQ-003 SHALL have port clk, input, 1: sole clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1: level request to power the mixer on.
REQ-006 SHALL have port cfg_valid, input, 1: gain write request.
REQ-007 SHALL have port cfg_ready, output, 1: gain write can be accepted this cycle.
REQ-008 SHALL have port cfg_ota, input, 1: requested OTA gain.
REQ-009 SHALL have port cfg_buff, input, 2: requested buffer gain.
REQ-010 SHALL have port pd, output, 1: mixer power-down, active-high.
REQ-011 SHALL have port ota, output, 1: mixer OTA gain.
REQ-012 SHALL have port buff, output, 2: mixer buffer gain.
REQ-013 SHALL have port mixer_ready, output, 1: mixer powered and settled, output valid.
REQ-014 SHALL have port busy, output, 1: settle in progress.
REQ-015 SHALL have port gain_nondefault, output, 1: ota != 1 or buff != 2'b01 while pd == 0.

Function
REQ-016 SHALL implement FSM states OFF, SETTLE, ON; all outputs registered.
REQ-017 OFF: pd=1, mixer_ready=0, busy=0; en==1 -> SETTLE next cycle, pd=0, counter cleared to 0.
REQ-018 SETTLE: pd=0, busy=1, mixer_ready=0; counter increments by 1 each cycle; at count SETTLE_CYCLES-1 -> ON.
REQ-019 Timing: en sampled high in OFF at cycle T -> pd=0 from T+1, mixer_ready=1 from T+1+SETTLE_CYCLES.
REQ-020 ON: pd=0, mixer_ready=1, busy=0; en==0 -> OFF next cycle (pd=1, mixer_ready=0).
REQ-021 en==0 in SETTLE -> OFF next cycle, settle aborted, counter cleared.
REQ-022 cfg_ready=1 only in OFF or ON; transfer when cfg_valid && cfg_ready; ota/buff update the next cycle.
REQ-023 Transfer in ON with en==1 -> SETTLE, counter cleared, mixer_ready=0 next cycle (re-settle after gain change).
REQ-024 Transfer in OFF -> gains updated, state stays OFF.
REQ-025 Transfer in ON with en==0 same cycle -> gains updated, state OFF, no settle.
REQ-026 cfg_valid during SETTLE SHALL be ignored (no transfer); requester holds cfg_valid until cfg_ready.
REQ-027 Counter SHALL never wrap; it stays in 0..SETTLE_CYCLES-1.
REQ-028 gain_nondefault SHALL be evaluated from registered ota/buff/pd, updated same cycle as those outputs.

Reset
REQ-029 rst==1 at a clock edge SHALL force: state OFF, pd=1, ota=1, buff=2'b01, mixer_ready=0, busy=0, cfg_ready=1, gain_nondefault=0, counter=0.
REQ-030 rst SHALL take priority over en and cfg_valid, including mid-SETTLE; after release, en high SHALL restart the full settle.

Structure
REQ-031 Package mixer_ctrl_pkg SHALL hold the state enum, OTA_DEFAULT=1'b1, BUFF_DEFAULT=2'b01.
REQ-032 Settle timer SHALL be one sub-module, mixer_ctrl_settle_cnt (clear, enable, done at SETTLE_CYCLES-1).

Verification
REQ-033 SETTLE_CYCLES=4: rst, then en=1 at cycle 10 -> pd=0 at 11, busy 11..14, mixer_ready=1 at 15.
REQ-034 In ON, write cfg_ota=0, cfg_buff=2'b10 -> ota=0, buff=10, gain_nondefault=1, mixer_ready low for 4 cycles then high.
REQ-035 en dropped 2 cycles into SETTLE -> pd=1 next cycle, mixer_ready never asserted; en re-raised -> full 4-cycle settle.
REQ-036 cfg_valid held through SETTLE -> cfg_ready=0, no gain change until ON, then accepted and re-settle.
REQ-037 rst mid-SETTLE with ota=0 -> next cycle pd=1, ota=1, buff=01, busy=0, state OFF.
REQ-038 Write in OFF then en=0/cfg_valid=1 in ON same cycle -> gains updated, pd=1, gain_nondefault=0.
